rat_path_follower: RTL
======================

Name: rat_path_follower

Overview:
Consumer end of the rat-maze Move stream. It takes the 2-bit moves that the solver emits from its output stack, one per handshake, and replays them from the start cell (0,0). For every step it reads the maze memory to confirm the target cell is free. It reports DONE when the replayed path ends exactly on the goal cell (max,max), and otherwise reports ERROR with a cause code. It sits between the solver datapath's Move output and a second read port of the maze map.

Parameters:
COORD_W, 4, coordinate width; the goal cell is (2^COORD_W-1, 2^COORD_W-1).
STEP_W, 8, step counter width.
MAX_STEPS, 255, maximum accepted moves; must be at most 2^STEP_W-1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin replay; honoured only in IDLE, DONE or ERROR
move_valid  in  1  a move is presented
move  in  2  direction: 00 X-1, 01 Y+1, 10 Y-1, 11 X+1
move_last  in  1  marks the final move of the path; qualified by move_valid
move_ready  out  1  follower accepts a move this cycle
rd_x  out  COORD_W  maze read address X
rd_y  out  COORD_W  maze read address Y
rd_data  in  1  maze cell; 1 = wall; valid one cycle after the address
cur_x  out  COORD_W  committed position X
cur_y  out  COORD_W  committed position Y
step_count  out  STEP_W  number of committed moves
busy  out  1  replay in progress
done  out  1  path verified; level output
error  out  1  path rejected; level output
err_code  out  3  0 none, 1 out-of-bounds, 2 wall, 3 step overflow, 4 short path, 5 long path

Behaviour:
- Reset (async, rst=1): state IDLE; cur_x, cur_y, rd_x, rd_y, step_count = 0; move_ready, busy, done, error = 0; err_code = 0.
- FSM states: IDLE, WAIT_MOVE, READ, EVAL, DONE, ERROR.
- IDLE / DONE / ERROR, on start=1:
  - next state WAIT_MOVE
  - cur = (0,0), step_count = 0
  - done, error, err_code cleared
- start in any other state is ignored.
- WAIT_MOVE:
  - move_ready = 1, busy = 1.
  - On move_valid & move_ready:
    - if step_count == MAX_STEPS -> ERROR, code 3
    - else if the move leaves the grid (X-1 at x=0, Y+1 at y=max, Y-1 at y=0, X+1 at x=max) -> ERROR, code 1
    - else latch the candidate coordinate into nxt and the last flag into a register, then -> READ.
  - Bounds and overflow are checked the same cycle, with no memory access. Overflow has priority over bounds.
- READ:
  - rd_x/rd_y = nxt; move_ready = 0.
  - -> EVAL unconditionally.
- EVAL:
  - rd_data is valid; rd_x/rd_y are still held at nxt.
  - rd_data=1 -> ERROR, code 2; cur unchanged.
  - Else commit: cur = nxt and step_count += 1. Then:
    - goal & last -> DONE
    - goal & !last -> ERROR, code 5
    - !goal & last -> ERROR, code 4
    - else -> WAIT_MOVE
- Throughput: one move every 3 cycles. Moves are accepted only in WAIT_MOVE, so move_ready is low in READ and EVAL.
- Outside READ/EVAL, rd_x/rd_y equal cur.
- DONE / ERROR: done or error held high; cur, step_count and err_code frozen; move_ready = 0.
- done and error are never high together.
- busy = 1 in WAIT_MOVE, READ and EVAL.
- Reset mid-replay aborts immediately to the reset values. Any in-flight move is discarded and the upstream must re-present it.
- The start cell (0,0) is not read; it is free by construction.

Decomposition:
- Package rat_pkg holds:
  - move_t enum: MV_XDEC=2'b00, MV_YINC=2'b01, MV_YDEC=2'b10, MV_XINC=2'b11
  - err_t enum with the codes listed under err_code
  - fsm state enum
- One combinational sub-module, rat_coord_step:
  - inputs: x, y, move
  - outputs: nx, ny, oob
  - shared with future solver rework; the FSM stays in the top module.

Test Plan:
- start, then moves 11 ×15 and 01 ×15 with last on the 30th, memory all-free -> done=1, cur=(15,15), step_count=30, err_code=0, each move accepted 3 cycles apart.
- start, first move 00 at (0,0) -> error=1, err_code=1, cur=(0,0), step_count=0, no rd cycle issued.
- Wall at (1,0), first move 11 -> rd_x=1, rd_y=0 in READ/EVAL, then error=1, err_code=2, cur=(0,0).
- Moves 11, 01 with last=1 on the second, free memory -> error=1, err_code=4, cur=(1,1), step_count=2.
- Full path to (15,15) with last=0 on the final move -> err_code=5. Separately, MAX_STEPS=3 with 4 moves -> err_code=3 on the 4th, step_count=3.
- Assert rst during READ -> all outputs at reset values asynchronously. Then start -> normal replay from (0,0), and a start pulse during WAIT_MOVE is ignored.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared types for the rat-maze path follower: move encoding, error
// cause codes and the replay FSM state encoding.
package rat_pkg;

  typedef enum logic [1:0] {
    MV_XDEC = 2'b00,
    MV_YINC = 2'b01,
    MV_YDEC = 2'b10,
    MV_XINC = 2'b11
  } move_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_OOB   = 3'd1,
    ERR_WALL  = 3'd2,
    ERR_OVF   = 3'd3,
    ERR_SHORT = 3'd4,
    ERR_LONG  = 3'd5
  } err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MOVE,
    S_READ,
    S_EVAL,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/rat_coord_step.sv
// One grid step: candidate coordinate for a move plus an out-of-grid flag.
// nx/ny wrap when oob is set and must not be used in that case.
module rat_coord_step
  import rat_pkg::*;
#(
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  move_t              move,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny,
  output logic               oob
);

  // Apply the move and flag any step off the edge of the grid
  always_comb begin
    nx  = x;
    ny  = y;
    oob = 1'b0;
    unique case (move)
      MV_XDEC: begin
        oob = (x == '0);
        nx  = x - COORD_W'(1);
      end
      MV_YINC: begin
        oob = (y == '1);
        ny  = y + COORD_W'(1);
      end
      MV_YDEC: begin
        oob = (y == '0);
        ny  = y - COORD_W'(1);
      end
      MV_XINC: begin
        oob = (x == '1);
        nx  = x + COORD_W'(1);
      end
    endcase
  end

endmodule

// File: rtl/rat_path_follower.sv
// Replays the solver's move stream from (0,0), checking each target cell
// against the maze map, and reports DONE on an exact finish at the goal
// corner or ERROR with a cause code.
module rat_path_follower
  import rat_pkg::*;
#(
  parameter int COORD_W   = 4,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               move_valid,
  input  logic [1:0]         move,
  input  logic               move_last,
  output logic               move_ready,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic               rd_data,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic [STEP_W-1:0]  step_count,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         err_code
);

  state_t             state, state_nxt;
  logic [COORD_W-1:0] nxt_x, nxt_y;
  logic [COORD_W-1:0] step_x, step_y;
  logic               step_oob;
  logic               last_q;
  logic               restart, accept, ovf, goal;

  rat_coord_step #(.COORD_W(COORD_W)) u_step (
    .x    (cur_x),
    .y    (cur_y),
    .move (move_t'(move)),
    .nx   (step_x),
    .ny   (step_y),
    .oob  (step_oob)
  );

  // start only counts when no replay is running
  assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign accept  = (state == S_WAIT_MOVE) && move_valid;
  assign ovf     = (step_count == STEP_W'(MAX_STEPS));
  assign goal    = (&nxt_x) && (&nxt_y);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; overflow and bounds are resolved without a map read
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: if (restart) state_nxt = S_WAIT_MOVE;
      S_WAIT_MOVE: begin
        if (accept) begin
          if (ovf || step_oob) state_nxt = S_ERROR;
          else                 state_nxt = S_READ;
        end
      end
      S_READ: state_nxt = S_EVAL;
      S_EVAL: begin
        if (rd_data)              state_nxt = S_ERROR;
        else if (goal && last_q)  state_nxt = S_DONE;
        else if (goal || last_q)  state_nxt = S_ERROR;
        else                      state_nxt = S_WAIT_MOVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the map address points at the candidate
  // cell only while its read is in flight
  always_comb begin
    move_ready = (state == S_WAIT_MOVE);
    busy       = (state == S_WAIT_MOVE) || (state == S_READ) || (state == S_EVAL);
    done       = (state == S_DONE);
    error      = (state == S_ERROR);
    if (state == S_READ || state == S_EVAL) begin
      rd_x = nxt_x;
      rd_y = nxt_y;
    end else begin
      rd_x = cur_x;
      rd_y = cur_y;
    end
  end

  // Position, step counter, candidate latch and error cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x      <= '0;
      cur_y      <= '0;
      nxt_x      <= '0;
      nxt_y      <= '0;
      last_q     <= 1'b0;
      step_count <= '0;
      err_code   <= ERR_NONE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (restart) begin
            cur_x      <= '0;
            cur_y      <= '0;
            step_count <= '0;
            err_code   <= ERR_NONE;
          end
        end
        S_WAIT_MOVE: begin
          if (accept) begin
            if (ovf) begin
              err_code <= ERR_OVF;
            end else if (step_oob) begin
              err_code <= ERR_OOB;
            end else begin
              nxt_x  <= step_x;
              nxt_y  <= step_y;
              last_q <= move_last;
            end
          end
        end
        S_EVAL: begin
          if (rd_data) begin
            err_code <= ERR_WALL;
          end else begin
            cur_x      <= nxt_x;
            cur_y      <= nxt_y;
            step_count <= step_count + STEP_W'(1);
            if (goal && !last_q)      err_code <= ERR_LONG;
            else if (!goal && last_q) err_code <= ERR_SHORT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
